// File: rtl/qr_job_ctrl.sv
// qr_job_ctrl: job sequencer around the combinational 2x2 complex QR datapath.
// Registers one H per handshake and holds it for a multicycle settle window.
// It then captures Q/R with a subcarrier tag and a singular flag, and offers
// the result downstream until it is accepted.
module qr_job_ctrl #(
  parameter int unsigned W             = 28,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_SC        = 64,
  parameter int unsigned IDX_W         = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*W-1:0]     h_in,
  output logic [8*W-1:0]     dp_h,
  input  logic [8*W-1:0]     dp_q,
  input  logic [8*W-1:0]     dp_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*W-1:0]     q_out,
  output logic [8*W-1:0]     r_out,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0]       CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SC - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   job_q, job_d;
  logic [8*W-1:0]     dp_h_q, dp_h_d;
  logic [8*W-1:0]     q_q, q_d;
  logic [8*W-1:0]     r_q, r_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic               vld_q, vld_d;
  logic               accept;
  logic               singular;

  // R11r is element 0 and R22r is element 6 of the packed R bus
  assign singular = (dp_r[W-1:0] == '0) || (dp_r[7*W-1:6*W] == '0);

  // Next-state and handshake logic; a retire in HOLD may coincide with a new
  // accept so the load of a fresh job is applied after the per-state update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    job_d    = job_q;
    dp_h_d   = dp_h_q;
    q_d      = q_q;
    r_d      = r_q;
    idx_d    = idx_q;
    err_d    = err_q;
    vld_d    = vld_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          q_d     = dp_q;
          r_d     = dp_r;
          idx_d   = tag_q;
          err_d   = singular;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      dp_h_d  = h_in;
      cnt_d   = CNT_INIT;
      tag_d   = job_q;
      job_d   = (job_q == IDX_LAST) ? '0 : job_q + 1'b1;
      state_d = SETTLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      job_q   <= '0;
      dp_h_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      job_q   <= job_d;
      dp_h_q  <= dp_h_d;
      q_q     <= q_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign dp_h      = dp_h_q;
  assign q_out     = q_q;
  assign r_out     = r_q;
  assign out_idx   = idx_q;
  assign out_err   = err_q;
  assign out_valid = vld_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qr_job_ctrl.sv
// Bench for qr_job_ctrl: two instances (settle 4 and settle 1) share the same
// input stimulus. Each is checked every cycle against a timestamp-based job
// model: a job accepted at edge E yields a result valid from edge E+S onward.
module tb_qr_job_ctrl;

  localparam int unsigned W      = 28;
  localparam int unsigned NUM_SC = 64;
  localparam int unsigned IDX_W  = 6;
  localparam logic [8*W-1:0] QMASK = {8{28'h5A5A5A5}};

  logic clk;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [8*W-1:0] h_in;

  logic [8*W-1:0] dph [2];
  logic [8*W-1:0] dpq [2];
  logic [8*W-1:0] dpr [2];
  logic [8*W-1:0] qo  [2];
  logic [8*W-1:0] ro  [2];
  logic [IDX_W-1:0] oi [2];
  logic ir [2];
  logic ov [2];
  logic oe [2];
  logic bz [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Stand-in datapath: R mirrors H, Q is H with a fixed pattern flipped
  assign dpr[0] = dph[0];
  assign dpq[0] = dph[0] ^ QMASK;
  assign dpr[1] = dph[1];
  assign dpq[1] = dph[1] ^ QMASK;

  qr_job_ctrl #(.W(W), .SETTLE_CYCLES(4), .NUM_SC(NUM_SC), .IDX_W(IDX_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .h_in(h_in), .dp_h(dph[0]), .dp_q(dpq[0]), .dp_r(dpr[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .q_out(qo[0]), .r_out(ro[0]),
    .out_idx(oi[0]), .out_err(oe[0]), .busy(bz[0]));

  qr_job_ctrl #(.W(W), .SETTLE_CYCLES(1), .NUM_SC(NUM_SC), .IDX_W(IDX_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .h_in(h_in), .dp_h(dph[1]), .dp_q(dpq[1]), .dp_r(dpr[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .q_out(qo[1]), .r_out(ro[1]),
    .out_idx(oi[1]), .out_err(oe[1]), .busy(bz[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one set per instance
  int             S_OF [2] = '{4, 1};
  int             cyc;
  bit             m_have [2];
  int             m_rdy_at [2];
  logic [8*W-1:0] m_h [2];
  logic [8*W-1:0] m_dph [2];
  int             m_idx [2];
  int             m_next [2];
  logic [8*W-1:0] m_oq [2];
  logic [8*W-1:0] m_or [2];
  int             m_oidx [2];
  bit             m_oerr [2];

  function automatic logic [W-1:0] elem(logic [8*W-1:0] h, int k);
    return h[k*W +: W];
  endfunction

  function automatic logic [8*W-1:0] rand_h();
    logic [8*W-1:0] h;
    h = '0;
    for (int k = 0; k < 8; k++)
      if ($urandom_range(0, 3) != 0) h[k*W +: W] = W'($urandom);
    return h;
  endfunction

  task automatic chk(string tag, int d, logic [8*W-1:0] obs, logic [8*W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] at cycle %0d: observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_have[d] = 1'b0; m_rdy_at[d] = 0; m_h[d] = '0; m_dph[d] = '0;
      m_idx[d] = 0; m_next[d] = 0; m_oq[d] = '0; m_or[d] = '0;
      m_oidx[d] = 0; m_oerr[d] = 1'b0;
    end
  endtask

  // Compare one instance against the model for the current cycle
  task automatic check_dut(int d, output bit ev, output bit eir);
    ev = m_have[d] && (cyc >= m_rdy_at[d]);
    if (m_have[d] && cyc == m_rdy_at[d]) begin
      m_oq[d]   = m_h[d] ^ QMASK;
      m_or[d]   = m_h[d];
      m_oidx[d] = m_idx[d];
      m_oerr[d] = (elem(m_h[d], 0) == '0) || (elem(m_h[d], 6) == '0);
    end
    eir = !m_have[d] || (ev && out_ready);
    chk("in_ready",  d, ir[d], eir);
    chk("out_valid", d, ov[d], ev);
    chk("busy",      d, bz[d], m_have[d]);
    chk("dp_h",      d, dph[d], m_dph[d]);
    chk("q_out",     d, qo[d], m_oq[d]);
    chk("r_out",     d, ro[d], m_or[d]);
    chk("out_idx",   d, oi[d], m_oidx[d]);
    chk("out_err",   d, oe[d], m_oerr[d]);
  endtask

  // One clock cycle: drive inputs, check, advance the model across the edge
  task automatic cycle(bit iv, logic [8*W-1:0] h, bit ordy);
    bit ev, eir;
    in_valid = iv; h_in = h; out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_dut(d, ev, eir);
      if (ev && ordy) m_have[d] = 1'b0;
      if (iv && eir) begin
        m_have[d]   = 1'b1;
        m_rdy_at[d] = cyc + 1 + S_OF[d];
        m_h[d]      = h;
        m_dph[d]    = h;
        m_idx[d]    = m_next[d];
        m_next[d]   = (m_next[d] + 1) % NUM_SC;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    bit ev, eir;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_dut(d, ev, eir);
    @(posedge clk); #1;
    cyc++;
    for (int d = 0; d < 2; d++) check_dut(d, ev, eir);
    rst_n = 1'b1;
  endtask

  logic [8*W-1:0] h;

  initial begin
    cyc = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; h_in = '0;
    model_reset();
    @(posedge clk); #1;
    cyc++;
    do_reset();

    // Single job, element 0 = 10000, downstream always ready
    h = '0; h[W-1:0] = W'(10000);
    cycle(1'b1, h, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Back-pressure in HOLD with a pending input, then same-edge retire/accept
    cycle(1'b1, rand_h(), 1'b0);
    h = rand_h();
    repeat (10) cycle(1'b1, h, 1'b0);
    cycle(1'b1, h, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Singular result, then a regular one
    cycle(1'b1, '0, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);
    h = '0; h[W-1:0] = W'(30000); h[6*W +: W] = W'(40000);
    cycle(1'b1, h, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);

    // Reset while the settle-4 instance sits at count 2
    cycle(1'b1, rand_h(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    h = rand_h(); h[W-1:0] = W'(7);
    cycle(1'b1, h, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Back-to-back jobs past the index wrap
    do_reset();
    repeat (65 * 5 + 5) cycle(1'b1, rand_h(), 1'b1);

    // Random traffic with random back-pressure
    repeat (400) cycle(($urandom_range(0, 2) != 0), rand_h(), ($urandom_range(0, 9) < 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
